// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out front end for the serial shift chain.
// A WIDTH-bit word is accepted with a valid/ready handshake, then sent out one
// bit per clock while shift_en is high. serial_valid marks each frame bit and
// frame_last marks the final one. After each frame the block can hold off the
// next load for GAP_CYCLES idle clocks.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter int LSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_last,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYCLES);

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       gap_cnt;

  logic             emit_bit;
  logic [WIDTH-1:0] shift_next;

  assign load_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);

  // Select the bit leaving the register and the register's zero-filled next value.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    emit_bit   = 1'b0;
    shift_next = shift_reg;
    if (LSB_FIRST != 0) begin
      emit_bit   = shift_reg[0];
      shift_next = shift_reg >> 1;
    end else begin
      emit_bit   = shift_reg[WIDTH-1];
      shift_next = shift_reg << 1;
    end
  end

  // Control FSM, datapath and registered serial outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_last   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          serial_out   <= 1'b0;
          serial_valid <= 1'b0;
          frame_last   <= 1'b0;
          if (load_valid && load_ready) begin
            shift_reg <= data_in;
            bit_cnt   <= '0;
            state     <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (shift_en) begin
            serial_out   <= emit_bit;
            shift_reg    <= shift_next;
            serial_valid <= 1'b1;
            bit_cnt      <= bit_cnt + 1'b1;
            frame_last   <= (bit_cnt == LAST_IDX);
            if (bit_cnt == LAST_IDX) begin
              if (GAP_CYCLES > 0) begin
                gap_cnt <= GAP_LOAD;
                state   <= ST_GAP;
              end else begin
                state <= ST_IDLE;
              end
            end
          end else begin
            // Stall: serial_out, shift_reg and bit_cnt hold; only the qualifiers drop.
            serial_valid <= 1'b0;
            frame_last   <= 1'b0;
          end
        end

        ST_GAP: begin
          serial_out   <= 1'b0;
          serial_valid <= 1'b0;
          frame_last   <= 1'b0;
          gap_cnt      <= gap_cnt - 8'd1;
          if (gap_cnt == 8'd1) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer. Three instances cover LSB-first with no
// gap, MSB-first, and a 3-clock inter-frame gap. A small model of the 4-bit
// downstream serial stage (registered output) is chained on the LSB-first one.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Instance A: WIDTH=8, LSB_FIRST=1, GAP_CYCLES=0
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0, a_en = 1'b0;
  logic       a_ready, a_sout, a_svalid, a_last, a_busy;

  // Instance M: WIDTH=8, LSB_FIRST=0, GAP_CYCLES=0
  logic [7:0] m_data = '0;
  logic       m_valid = 1'b0, m_en = 1'b0;
  logic       m_ready, m_sout, m_svalid, m_last, m_busy;

  // Instance G: WIDTH=8, LSB_FIRST=1, GAP_CYCLES=3
  logic [7:0] g_data = '0;
  logic       g_valid = 1'b0, g_en = 1'b0;
  logic       g_ready, g_sout, g_svalid, g_last, g_busy;

  int checks   = 0;
  int failures = 0;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_data), .load_valid(a_valid), .load_ready(a_ready),
    .shift_en(a_en), .serial_out(a_sout), .serial_valid(a_svalid), .frame_last(a_last),
    .busy(a_busy)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(0), .GAP_CYCLES(0)) dut_m (
    .clk(clk), .rst(rst), .data_in(m_data), .load_valid(m_valid), .load_ready(m_ready),
    .shift_en(m_en), .serial_out(m_sout), .serial_valid(m_svalid), .frame_last(m_last),
    .busy(m_busy)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1), .GAP_CYCLES(3)) dut_g (
    .clk(clk), .rst(rst), .data_in(g_data), .load_valid(g_valid), .load_ready(g_ready),
    .shift_en(g_en), .serial_out(g_sout), .serial_valid(g_svalid), .frame_last(g_last),
    .busy(g_busy)
  );

  // Downstream 4-bit serial shift stage with registered output, fed by dut_a.
  logic [3:0] ds_sr;
  logic       ds_out;
  always @(posedge clk) begin
    if (rst) begin
      ds_sr  <= '0;
      ds_out <= 1'b0;
    end else begin
      ds_sr  <= {ds_sr[2:0], a_sout};
      ds_out <= ds_sr[3];
    end
  end

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    a_valid = 1'b1;
    a_data  = 8'hFF;
    a_en    = 1'b1;
    tick();
    tick();
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: ready=%b busy=%b, expected ready=1 busy=0", a_ready, a_busy);
    end
    checks++;
    if ({a_sout, a_svalid, a_last} !== 3'b000 || {g_sout, g_svalid, g_last, g_busy} !== 4'b0000
        || {m_sout, m_svalid, m_last, m_busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: a=%b%b%b g=%b%b%b%b m=%b%b%b%b, expected all 0",
               a_sout, a_svalid, a_last, g_sout, g_svalid, g_last, g_busy,
               m_sout, m_svalid, m_last, m_busy);
    end
    rst     = 1'b0;
    a_valid = 1'b0;
    tick();
    // The word offered while rst was high must not have been captured.
    checks++;
    if (a_busy !== 1'b0 || a_svalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins_load: busy=%b svalid=%b, expected 0 0", a_busy, a_svalid);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] seq;
    seq     = 8'b0000_0001;  // emission order, element 0 first: 1,0,0,0,0,0,0,0
    a_data  = 8'h01;
    a_valid = 1'b1;
    a_en    = 1'b1;
    tick();  // E0: capture
    a_valid = 1'b0;
    a_data  = 8'hFF;  // changing data after acceptance must not affect the frame
    checks++;
    if (a_busy !== 1'b1 || a_ready !== 1'b0 || a_svalid !== 1'b0) begin
      failures++;
      $display("FAIL lsb_capture: busy=%b ready=%b svalid=%b, expected 1 0 0", a_busy, a_ready, a_svalid);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (a_sout !== seq[i-1] || a_svalid !== 1'b1 || a_last !== (i == 8) || a_busy !== (i != 8)) begin
        failures++;
        $display("FAIL lsb_bit%0d: sout=%b svalid=%b last=%b busy=%b, expected %b 1 %b %b",
                 i, a_sout, a_svalid, a_last, a_busy, seq[i-1], (i == 8), (i != 8));
      end
    end
    tick();
    checks++;
    if (a_svalid !== 1'b0 || a_last !== 1'b0 || a_sout !== 1'b0) begin
      failures++;
      $display("FAIL lsb_after_frame: sout=%b svalid=%b last=%b, expected 0 0 0", a_sout, a_svalid, a_last);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] seq;
    seq     = 8'b1000_0000;  // emission order, element 0 first: 0,0,0,0,0,0,0,1
    m_data  = 8'h01;
    m_valid = 1'b1;
    m_en    = 1'b1;
    tick();
    m_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (m_sout !== seq[i-1] || m_svalid !== 1'b1 || m_last !== (i == 8)) begin
        failures++;
        $display("FAIL msb_bit%0d: sout=%b svalid=%b last=%b, expected %b 1 %b",
                 i, m_sout, m_svalid, m_last, seq[i-1], (i == 8));
      end
    end
    tick();
    checks++;
    if (m_busy !== 1'b0 || m_svalid !== 1'b0) begin
      failures++;
      $display("FAIL msb_after_frame: busy=%b svalid=%b, expected 0 0", m_busy, m_svalid);
    end
  endtask

  task automatic test_stall();
    logic [7:0] seq;
    logic [9:0] en_pat;
    logic       held;
    int         k;
    seq    = 8'b1011_0100;   // emission order, element 0 first: 0,0,1,0,1,1,0,1
    en_pat = 10'b11_1101_1011;  // element c-1 is shift_en for SHIFT clock c; low on 3 and 6
    held   = 1'b0;
    k      = 0;
    a_data  = 8'hB4;
    a_valid = 1'b1;
    a_en    = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      a_en = en_pat[c-1];
      tick();
      if (en_pat[c-1]) begin
        held = seq[k];
        k++;
        checks++;
        if (a_sout !== held || a_svalid !== 1'b1 || a_last !== (k == 8)) begin
          failures++;
          $display("FAIL stall_clk%0d: sout=%b svalid=%b last=%b, expected %b 1 %b",
                   c, a_sout, a_svalid, a_last, held, (k == 8));
        end
      end else begin
        checks++;
        if (a_sout !== held || a_svalid !== 1'b0 || a_last !== 1'b0 || a_busy !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold%0d: sout=%b svalid=%b last=%b busy=%b, expected %b 0 0 1",
                   c, a_sout, a_svalid, a_last, a_busy, held);
        end
      end
    end
    checks++;
    if (a_busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_len: busy=%b after 10 SHIFT clocks, expected 0", a_busy);
    end
    a_en = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back_gap();
    int low_cnt;
    g_data  = 8'hFF;
    g_valid = 1'b1;
    g_en    = 1'b1;
    tick();  // E0: capture 0xFF
    g_data  = 8'h00;  // next word offered immediately, valid stays high
    low_cnt = (g_ready == 1'b0) ? 1 : 0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (g_ready == 1'b0) low_cnt++;
      if (c <= 8) begin
        checks++;
        if (g_sout !== 1'b1 || g_svalid !== 1'b1 || g_last !== (c == 8)) begin
          failures++;
          $display("FAIL gap_f1_bit%0d: sout=%b svalid=%b last=%b, expected 1 1 %b",
                   c, g_sout, g_svalid, g_last, (c == 8));
        end
      end else begin
        checks++;
        if (g_sout !== 1'b0 || g_svalid !== 1'b0 || g_last !== 1'b0) begin
          failures++;
          $display("FAIL gap_idle%0d: sout=%b svalid=%b last=%b, expected 0 0 0",
                   c, g_sout, g_svalid, g_last);
        end
      end
    end
    checks++;
    if (low_cnt !== 11 || g_ready !== 1'b1) begin
      failures++;
      $display("FAIL gap_ready_low: low clocks=%0d ready=%b, expected 11 1", low_cnt, g_ready);
    end
    tick();  // second capture
    g_valid = 1'b0;
    checks++;
    if (g_busy !== 1'b1 || g_svalid !== 1'b0) begin
      failures++;
      $display("FAIL gap_second_capture: busy=%b svalid=%b, expected 1 0", g_busy, g_svalid);
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (g_sout !== 1'b0 || g_svalid !== 1'b1 || g_last !== (c == 8)) begin
        failures++;
        $display("FAIL gap_f2_bit%0d: sout=%b svalid=%b last=%b, expected 0 1 %b",
                 c, g_sout, g_svalid, g_last, (c == 8));
      end
    end
    for (int c = 1; c <= 3; c++) tick();
    checks++;
    if (g_ready !== 1'b1 || g_busy !== 1'b0) begin
      failures++;
      $display("FAIL gap_no_third: ready=%b busy=%b, expected 1 0", g_ready, g_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] seq;
    int         stray;
    seq     = 8'b1010_0101;  // 0xA5 emission order: 1,0,1,0,0,1,0,1
    a_data  = 8'hA5;
    a_valid = 1'b1;
    a_en    = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (a_sout !== seq[i-1] || a_svalid !== 1'b1) begin
        failures++;
        $display("FAIL abort_bit%0d: sout=%b svalid=%b, expected %b 1", i, a_sout, a_svalid, seq[i-1]);
      end
    end
    rst = 1'b1;
    tick();  // edge that would have emitted bit 4
    rst = 1'b0;
    checks++;
    if ({a_sout, a_svalid, a_last, a_busy, a_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL abort_outputs: sout=%b svalid=%b last=%b busy=%b ready=%b, expected 0 0 0 0 1",
               a_sout, a_svalid, a_last, a_busy, a_ready);
    end
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_svalid !== 1'b0 || a_last !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL abort_residue: %0d clocks with svalid/last after abort, expected 0", stray);
    end
    seq     = 8'b0101_1010;  // 0x5A emission order: 0,1,0,1,1,0,1,0
    a_data  = 8'h5A;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (a_sout !== seq[i-1] || a_svalid !== 1'b1 || a_last !== (i == 8)) begin
        failures++;
        $display("FAIL reload_bit%0d: sout=%b svalid=%b last=%b, expected %b 1 %b",
                 i, a_sout, a_svalid, a_last, seq[i-1], (i == 8));
      end
    end
    tick();
  endtask

  task automatic test_downstream_chain();
    logic [7:0] seq;
    seq     = 8'b0000_1101;  // 0x0D emission order: 1,0,1,1,0,0,0,0
    a_data  = 8'h0D;
    a_valid = 1'b1;
    a_en    = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c <= 8) begin
        checks++;
        if (a_sout !== seq[c-1]) begin
          failures++;
          $display("FAIL chain_src%0d: sout=%b, expected %b", c, a_sout, seq[c-1]);
        end
      end
      if (c >= 6) begin
        checks++;
        if (ds_out !== seq[c-6]) begin
          failures++;
          $display("FAIL chain_out%0d: stage out=%b, expected %b", c, ds_out, seq[c-6]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_stall();
    test_back_to_back_gap();
    test_reset_mid_frame();
    test_downstream_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
